fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction prefetch stage between instruction memory and the IF/ID pipeline register of the 5-stage MIPS core. Generates sequential fetch addresses, issues single-cycle-latency instruction memory requests, and buffers returned words with their PC+4 in a small FIFO. Presents one instruction per cycle to ID, holding it under data stall. Flushes on branch/jump redirect from MEM. When empty, ID sees a NOP (all-zero word).

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, equals fetch_pc
imem_gnt  input  1  memory accepts request this cycle
imem_rdata  input  32  instruction word, valid the cycle after an accepted request
id_stall  input  1  ID cannot consume (dataStall)
redirect  input  1  taken branch/jump resolved in MEM
redirect_pc  input  32  new fetch target (NPCValue)
id_valid  output  1  head entry valid
id_instr  output  32  head instruction, 32'h0 when !id_valid
id_pc_plus4  output  32  PC+4 of head instruction, 32'h0 when !id_valid
occupancy  output  log2(DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, head=tail=0, count=0, inflight=0, all FIFO entries invalid. Outputs after reset: imem_req=0 during rst, id_valid=0, id_instr=0, id_pc_plus4=0, occupancy=0. rst overrides redirect and all other inputs.
- State: fetch_pc (32b), inflight (1b), inflight_pc (32b, address of the outstanding fetch), FIFO of DEPTH x {instr, pc_plus4}, head/tail pointers, count.
- Request: imem_req = !rst && !redirect && (count + inflight) < DEPTH. imem_addr = fetch_pc (combinational).
- Accept (imem_req && imem_gnt): fetch_pc <= fetch_pc+4, wraps modulo 2^32 (32'hFFFF_FFFC -> 0). inflight <= 1, inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Back-to-back accepts are allowed, giving one word per cycle at full throughput.
- Return: if inflight=1 and no redirect this cycle, write {imem_rdata, inflight_pc+4} at tail, tail++ (wraps at DEPTH).
- Credit rule: the request condition guarantees a push never hits a full FIFO. Overflow is unreachable and is checked by assertion.
- Pop: when id_valid && !id_stall, head++. Push and pop in the same cycle leave count unchanged.
- Empty FIFO: id_valid=0 and NOP outputs. A pop attempt on an empty FIFO has no effect.
- Latency: request accepted in cycle N -> FIFO write at end of N+1 -> id_valid=1 in N+2.
- Stall: while id_stall=1, head and outputs hold. Fetching continues until the FIFO is full.
- Redirect (priority over push, pop, and request):
  - Clear count, head, tail; set fetch_pc <= redirect_pc.
  - Drop any response arriving this cycle: inflight <= 0, no write.
  - imem_req=0 this cycle; the first request to redirect_pc is issued next cycle.
  - The flush happens even if id_stall=1.
- Redirect while empty and idle: only fetch_pc changes.
- Consecutive redirects: the last one wins.
- A redirect_pc that is not word-aligned is used as-is (no alignment fault handling).

Test Plan:
1. Reset, then imem returns addr-as-data, gnt=1, no stall -> id_instr 0x0,0x4,0x8,... from cycle 2 on, id_pc_plus4 = instr+4, one per cycle, occupancy stays <=2.
2. id_stall=1 from cycle 3 for 10 cycles, DEPTH=4 -> occupancy rises to 4, imem_req drops to 0. Outputs hold 0x4/0x8 throughout. After release, ordered words 0x4..0x1C appear with no gaps or duplicates.
3. redirect=1, redirect_pc=0x100 while occupancy=3 and a fetch is in flight -> next cycle id_valid=0, occupancy=0, imem_addr=0x100. The in-flight word is never presented. First valid is id_instr=0x100 two cycles after the request.
4. imem_gnt toggles 1,0,0,1 -> imem_addr holds during denied cycles. Delivered sequence is contiguous with no duplicated PCs.
5. RESET_PC=32'hFFFF_FFF8, no stall -> fetched addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. id_pc_plus4 for the FFFF_FFFC word is 0.
6. rst asserted mid-stream with redirect=1 and inflight=1 -> next cycle all outputs are zero, imem_addr=RESET_PC, and no stale word is written.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction memory request/response, ID-side delivery,
// and MEM-stage redirect, bundled for a single port on the fetch queue.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 4
) ();
   localparam int unsigned CntW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

   logic            imem_req;
   logic [31:0]     imem_addr;
   logic            imem_gnt;
   logic [31:0]     imem_rdata;
   logic            id_stall;
   logic            redirect;
   logic [31:0]     redirect_pc;
   logic            id_valid;
   logic [31:0]     id_instr;
   logic [31:0]     id_pc_plus4;
   logic [CntW-1:0] occupancy;

   // Fetch queue side
   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc_plus4, occupancy,
      input  imem_gnt, imem_rdata, id_stall, redirect, redirect_pc
   );

   // Memory / pipeline side
   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc_plus4, occupancy,
      output imem_gnt, imem_rdata, id_stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers returned
// words with their PC+4, and feeds ID one instruction per cycle.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int unsigned   PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CntW   = PtrW + 1;
   localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

   logic [31:0]     fetchPcQ;
   logic            inflightQ;
   logic [31:0]     inflightPcQ;
   logic [PtrW-1:0] headQ;
   logic [PtrW-1:0] tailQ;
   logic [CntW-1:0] countQ;
   logic [31:0]     instrMem [DEPTH];
   logic [31:0]     pcMem    [DEPTH];

   logic [CntW:0] credit;
   logic          req;
   logic          accept;
   logic          push;
   logic          pop;
   logic          headValid;

   // Request gating: buffered plus outstanding words must leave room for one more
   always_comb begin
      credit    = {1'b0, countQ} + {{CntW{1'b0}}, inflightQ};
      req       = !rst && !bus.redirect && (credit < DepthC);
      accept    = req && bus.imem_gnt;
      push      = inflightQ && !bus.redirect;
      headValid = (countQ != '0);
      pop       = headValid && !bus.id_stall;
   end

   // ID-facing outputs; NOP when the queue is empty
   always_comb begin
      bus.imem_req    = req;
      bus.imem_addr   = fetchPcQ;
      bus.id_valid    = headValid;
      bus.id_instr    = headValid ? instrMem[headQ] : 32'h0;
      bus.id_pc_plus4 = headValid ? pcMem[headQ] : 32'h0;
      bus.occupancy   = countQ;
   end

   // Control state: reset beats redirect, redirect beats push/pop/accept
   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPcQ    <= RESET_PC;
         inflightQ   <= 1'b0;
         inflightPcQ <= 32'h0;
         headQ       <= '0;
         tailQ       <= '0;
         countQ      <= '0;
      end else if (bus.redirect) begin
         fetchPcQ  <= bus.redirect_pc;
         inflightQ <= 1'b0;
         headQ     <= '0;
         tailQ     <= '0;
         countQ    <= '0;
      end else begin
         if (accept) begin
            fetchPcQ    <= fetchPcQ + 32'd4;
            inflightPcQ <= fetchPcQ;
         end
         inflightQ <= accept;
         if (push) tailQ <= tailQ + PtrW'(1);
         if (pop)  headQ <= headQ + PtrW'(1);
         case ({push, pop})
            2'b10:   countQ <= countQ + CntW'(1);
            2'b01:   countQ <= countQ - CntW'(1);
            default: countQ <= countQ;
         endcase
      end
   end

   // Storage write for the word returning from the previous cycle's fetch
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         instrMem[tailQ] <= bus.imem_rdata;
         pcMem[tailQ]    <= inflightPcQ + 32'd4;
      end
   end

   // The credit check in req makes a push into a full queue impossible
   assert property (@(posedge clk) disable iff (rst) !(push && countQ == DepthC[CntW-1:0]));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of fetched addresses.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst;
   logic rstB;

   fetch_queue_if #(.DEPTH(DEPTH)) ifA ();
   fetch_queue_if #(.DEPTH(DEPTH)) ifB ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dutA (
      .clk(clk),
      .rst(rst),
      .bus(ifA)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dutB (
      .clk(clk),
      .rst(rstB),
      .bus(ifB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus values applied at the next step
   logic        rstV   = 1'b1;
   logic        rstBV  = 1'b1;
   logic        gntV   = 1'b1;
   logic        stallV = 1'b0;
   logic        redirV = 1'b0;
   logic [31:0] rpcV   = 32'h0;

   // Memory model: returns the address presented in the previous cycle
   logic [31:0] lastA = 32'h0;
   logic [31:0] lastB = 32'h0;

   // Reference model of queue A
   logic [31:0] sbQ[$];
   logic [31:0] pcM    = 32'h0;
   int          occM   = 0;
   logic        inflM  = 1'b0;
   logic        modelOn = 1'b0;

   // Samples of the last step
   logic        sReq, sValid;
   logic [31:0] sAddr, sInstr, sPc, sOcc;
   logic        sValidB;
   logic [31:0] sAddrB, sInstrB, sPcB, sOccB;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, sample, check against model, advance model
   task automatic step();
      logic expReq;
      logic acc;
      @(negedge clk);
      rst             = rstV;
      rstB            = rstBV;
      ifA.imem_rdata  = lastA;
      ifA.imem_gnt    = gntV;
      ifA.id_stall    = stallV;
      ifA.redirect    = redirV;
      ifA.redirect_pc = rpcV;
      ifB.imem_rdata  = lastB;
      #1;
      sReq    = ifA.imem_req;
      sAddr   = ifA.imem_addr;
      sValid  = ifA.id_valid;
      sInstr  = ifA.id_instr;
      sPc     = ifA.id_pc_plus4;
      sOcc    = 32'(ifA.occupancy);
      sValidB = ifB.id_valid;
      sAddrB  = ifB.imem_addr;
      sInstrB = ifB.id_instr;
      sPcB    = ifB.id_pc_plus4;
      sOccB   = 32'(ifB.occupancy);
      lastA   = sAddr;
      lastB   = sAddrB;
      expReq  = !rstV && !redirV && ((occM + int'(inflM)) < int'(DEPTH));
      if (modelOn) begin
         check("req", 32'(sReq), 32'(expReq));
         check("addr", sAddr, pcM);
         check("occupancy", sOcc, 32'(occM));
         check("valid", 32'(sValid), 32'(occM != 0));
         if (occM != 0) begin
            check("instr", sInstr, sbQ[0]);
            check("pc_plus4", sPc, sbQ[0] + 32'd4);
         end else begin
            check("nop_instr", sInstr, 32'h0);
            check("nop_pc_plus4", sPc, 32'h0);
         end
      end
      if (rstV) begin
         sbQ.delete();
         pcM     = 32'h0;
         occM    = 0;
         inflM   = 1'b0;
         modelOn = 1'b1;
      end else if (redirV) begin
         sbQ.delete();
         pcM   = rpcV;
         occM  = 0;
         inflM = 1'b0;
      end else begin
         if (occM != 0 && !stallV) begin
            void'(sbQ.pop_front());
            occM--;
         end
         if (inflM) occM++;
         acc = expReq && gntV;
         if (acc) begin
            sbQ.push_back(pcM);
            pcM = pcM + 32'd4;
         end
         inflM = acc;
      end
      @(posedge clk);
   endtask

   initial begin
      logic [31:0] holdInstr;
      logic [3:0]  gntPat;
      logic [31:0] prevAddr;
      rst             = 1'b1;
      rstB            = 1'b1;
      ifA.imem_gnt    = 1'b1;
      ifA.imem_rdata  = 32'h0;
      ifA.id_stall    = 1'b0;
      ifA.redirect    = 1'b0;
      ifA.redirect_pc = 32'h0;
      ifB.imem_gnt    = 1'b1;
      ifB.imem_rdata  = 32'h0;
      ifB.id_stall    = 1'b0;
      ifB.redirect    = 1'b0;
      ifB.redirect_pc = 32'h0;

      // Reset
      rstV = 1'b1;
      step();
      step();
      check("rst_req", 32'(sReq), 32'h0);
      rstV = 1'b0;

      // Streaming with no stall: one word per cycle from cycle 2
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 0) begin
            check("post_rst_valid", 32'(sValid), 32'h0);
            check("post_rst_occ", sOcc, 32'h0);
            check("post_rst_addr", sAddr, 32'h0);
         end
         if (i >= 2) begin
            check("stream_valid", 32'(sValid), 32'h1);
            check("stream_instr", sInstr, 32'((i - 2) * 4));
         end
         check("stream_occ_le2", 32'(sOcc <= 32'd2), 32'h1);
      end

      // Stall: queue fills, requests stop, head holds
      stallV = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 0) holdInstr = sInstr;
         else check("stall_hold", sInstr, holdInstr);
      end
      check("stall_full_occ", sOcc, 32'd4);
      check("stall_full_req", 32'(sReq), 32'h0);
      stallV = 1'b0;
      for (int i = 0; i < 8; i++) step();

      // Redirect with three buffered words and a fetch in flight
      stallV = 1'b1;
      for (int i = 0; i < 10 && !(occM == 3 && inflM); i++) step();
      checks++;
      assert (occM == 3 && inflM) else begin
         errors++;
         $error("FAIL redirect_setup observed occ %0d inflight %0d expected occ 3 inflight 1",
                occM, inflM);
      end
      redirV = 1'b1;
      rpcV   = 32'h100;
      step();
      check("redir_req", 32'(sReq), 32'h0);
      redirV = 1'b0;
      stallV = 1'b0;
      step();
      check("redir_valid", 32'(sValid), 32'h0);
      check("redir_occ", sOcc, 32'h0);
      check("redir_addr", sAddr, 32'h100);
      step();
      check("redir_gap", 32'(sValid), 32'h0);
      step();
      check("redir_first_valid", 32'(sValid), 32'h1);
      check("redir_first_instr", sInstr, 32'h100);

      // Grant toggling 1,0,0,1: address holds while denied
      gntPat   = 4'b1001;
      prevAddr = 32'h0;
      for (int i = 0; i < 8; i++) begin
         gntV = gntPat[i % 4];
         step();
         if (i > 0 && !gntPat[(i - 1) % 4]) check("gnt_addr_hold", sAddr, prevAddr);
         prevAddr = sAddr;
      end
      gntV = 1'b1;

      // Reset overrides a redirect while a fetch is in flight
      step();
      rstV   = 1'b1;
      redirV = 1'b1;
      rpcV   = 32'h200;
      step();
      rstV   = 1'b0;
      redirV = 1'b0;
      step();
      check("rst_mid_valid", 32'(sValid), 32'h0);
      check("rst_mid_instr", sInstr, 32'h0);
      check("rst_mid_pc", sPc, 32'h0);
      check("rst_mid_occ", sOcc, 32'h0);
      check("rst_mid_addr", sAddr, 32'h0);
      step();
      check("rst_mid_no_stale", 32'(sValid), 32'h0);
      step();
      check("rst_mid_first", sInstr, 32'h0);

      // Address wrap on the second instance
      rstBV = 1'b0;
      step();
      check("wrap_addr0", sAddrB, 32'hFFFF_FFF8);
      check("wrap_rst_valid", 32'(sValidB), 32'h0);
      check("wrap_rst_occ", sOccB, 32'h0);
      step();
      check("wrap_addr1", sAddrB, 32'hFFFF_FFFC);
      step();
      check("wrap_addr2", sAddrB, 32'h0000_0000);
      check("wrap_instr0", sInstrB, 32'hFFFF_FFF8);
      check("wrap_pc0", sPcB, 32'hFFFF_FFFC);
      step();
      check("wrap_instr1", sInstrB, 32'hFFFF_FFFC);
      check("wrap_pc1", sPcB, 32'h0000_0000);
      step();
      check("wrap_instr2", sInstrB, 32'h0000_0000);
      check("wrap_pc2", sPcB, 32'h0000_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1);
   end
endmodule
